// File: rtl/pinwheel_bus_arbiter.sv
// ============================================================================
// Module   : pinwheel_bus_arbiter
// Purpose  : Round-robin TileLink-UL channel-A arbiter with an in-order source
//            FIFO that steers channel-D replies back to the issuing requester.
//            Optional macro PINWHEEL_ARB_PERF_EN builds per-requester grant
//            counters on perf_grants; otherwise perf_grants is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pinwheel_bus_arbiter #(
  parameter int NREQ       = 2,
  parameter int SRC_W      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset_n_in,
  input  logic [NREQ-1:0]               req_a_valid,
  output logic [NREQ-1:0]               req_a_ready,
  input  logic [3*NREQ-1:0]             req_a_opcode,
  input  logic [32*NREQ-1:0]            req_a_address,
  input  logic [4*NREQ-1:0]             req_a_mask,
  input  logic [32*NREQ-1:0]            req_a_data,
  output logic                          mem_a_valid,
  input  logic                          mem_a_ready,
  output logic [2:0]                    mem_a_opcode,
  output logic [31:0]                   mem_a_address,
  output logic [3:0]                    mem_a_mask,
  output logic [31:0]                   mem_a_data,
  output logic [SRC_W-1:0]              mem_a_source,
  input  logic                          mem_d_valid,
  output logic                          mem_d_ready,
  input  logic [2:0]                    mem_d_opcode,
  input  logic [31:0]                   mem_d_data,
  output logic [NREQ-1:0]               rsp_d_valid,
  input  logic [NREQ-1:0]               rsp_d_ready,
  output logic [2:0]                    rsp_d_opcode,
  output logic [31:0]                   rsp_d_data,
  output logic [$clog2(FIFO_DEPTH):0]   outstanding,
  output logic                          err_orphan_d,
  output logic [32*NREQ-1:0]            perf_grants
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = SRC_W + 1;

  // Held low until the first edge after reset release so that all
  // handshake outputs stay quiet while reset is asserted.
  logic                 run_q;

  logic                 slot_valid_q;
  logic [2:0]           slot_opcode_q;
  logic [31:0]          slot_address_q;
  logic [3:0]           slot_mask_q;
  logic [31:0]          slot_data_q;
  logic [SRC_W-1:0]     slot_source_q;
  logic [SRC_W-1:0]     ptr_q;

  logic [SRC_W-1:0]     fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic                 err_q;

  logic                 slot_free;
  logic                 fifo_empty;
  logic                 fifo_ok;
  logic                 d_fire;
  logic                 d_pop;
  logic                 d_orphan;
  logic                 grant_any;
  logic [SRC_W-1:0]     grant_idx;
  logic [SRC_W-1:0]     head;
  logic [SUM_W-1:0]     cand_w;
  logic [SRC_W-1:0]     cand;
  logic [2:0]           sel_opcode;
  logic [31:0]          sel_address;
  logic [3:0]           sel_mask;
  logic [31:0]          sel_data;

  assign slot_free  = !slot_valid_q || mem_a_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rd_ptr_q];
  assign d_fire     = mem_d_valid && mem_d_ready;
  assign d_pop      = d_fire && !fifo_empty;
  assign d_orphan   = d_fire && fifo_empty;
  assign fifo_ok    = (count_q < CNT_W'(FIFO_DEPTH)) || d_pop;

  // Round-robin scan starting one past the last granted requester.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_w    = '0;
    cand      = '0;
    if (run_q && slot_free && fifo_ok) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand_w = {1'b0, ptr_q} + SUM_W'(k);
        if (cand_w >= SUM_W'(NREQ)) begin
          cand_w = cand_w - SUM_W'(NREQ);
        end
        cand = cand_w[SRC_W-1:0];
        if (!grant_any && req_a_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    req_a_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a_ready[i] = grant_any && (grant_idx == SRC_W'(i));
    end
  end

  assign sel_opcode  = req_a_opcode[int'(grant_idx)*3 +: 3];
  assign sel_address = req_a_address[int'(grant_idx)*32 +: 32];
  assign sel_mask    = req_a_mask[int'(grant_idx)*4 +: 4];
  assign sel_data    = req_a_data[int'(grant_idx)*32 +: 32];

  always_ff @(posedge clock or negedge reset_n_in) begin
    if (!reset_n_in) begin
      run_q          <= 1'b0;
      slot_valid_q   <= 1'b0;
      slot_opcode_q  <= '0;
      slot_address_q <= '0;
      slot_mask_q    <= '0;
      slot_data_q    <= '0;
      slot_source_q  <= '0;
      ptr_q          <= SRC_W'(NREQ - 1);
    end else begin
      run_q <= 1'b1;
      if (grant_any) begin
        slot_valid_q   <= 1'b1;
        slot_opcode_q  <= sel_opcode;
        slot_address_q <= sel_address;
        slot_mask_q    <= sel_mask;
        slot_data_q    <= sel_data;
        slot_source_q  <= grant_idx;
        ptr_q          <= grant_idx;
      end else if (mem_a_ready) begin
        slot_valid_q <= 1'b0;
      end
    end
  end

  assign mem_a_valid   = slot_valid_q;
  assign mem_a_opcode  = slot_opcode_q;
  assign mem_a_address = slot_address_q;
  assign mem_a_mask    = slot_mask_q;
  assign mem_a_data    = slot_data_q;
  assign mem_a_source  = slot_source_q;

  // A beat arriving with nothing outstanding is drained and flagged.
  always_comb begin
    rsp_d_valid = '0;
    mem_d_ready = 1'b0;
    if (run_q) begin
      if (fifo_empty) begin
        mem_d_ready = 1'b1;
      end else begin
        rsp_d_valid[head] = mem_d_valid;
        mem_d_ready       = rsp_d_ready[head];
      end
    end
  end

  assign rsp_d_opcode = mem_d_opcode;
  assign rsp_d_data   = mem_d_data;

  assign count_d = count_q + CNT_W'(grant_any) - CNT_W'(d_pop);

  always_ff @(posedge clock or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (grant_any) begin
        fifo_q[wr_ptr_q] <= grant_idx;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (d_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      if (d_orphan) begin
        err_q <= 1'b1;
      end
    end
  end

  assign outstanding  = count_q;
  assign err_orphan_d = err_q;

`ifdef PINWHEEL_ARB_PERF_EN
  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_perf
      logic [31:0] grants_q;
      always_ff @(posedge clock or negedge reset_n_in) begin
        if (!reset_n_in) begin
          grants_q <= '0;
        end else if (req_a_ready[i]) begin
          grants_q <= grants_q + 32'd1;
        end
      end
      assign perf_grants[i*32 +: 32] = grants_q;
    end
  endgenerate
`else
  assign perf_grants = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pinwheel_bus_arbiter.sv
// ============================================================================
// Module   : tb_pinwheel_bus_arbiter
// Purpose  : Directed self-checking bench for pinwheel_bus_arbiter (NREQ=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pinwheel_bus_arbiter;

  localparam int NREQ  = 2;
  localparam int SRC_W = 1;
  localparam int DEPTH = 4;

  localparam logic [2:0] OP_GET   = 3'd4;
  localparam logic [2:0] OP_PUTP  = 3'd1;
  localparam logic [2:0] OP_ACK   = 3'd0;
  localparam logic [2:0] OP_ACKD  = 3'd1;

  logic                 clock;
  logic                 reset_n_in;
  logic [NREQ-1:0]      req_a_valid;
  logic [NREQ-1:0]      req_a_ready;
  logic [3*NREQ-1:0]    req_a_opcode;
  logic [32*NREQ-1:0]   req_a_address;
  logic [4*NREQ-1:0]    req_a_mask;
  logic [32*NREQ-1:0]   req_a_data;
  logic                 mem_a_valid;
  logic                 mem_a_ready;
  logic [2:0]           mem_a_opcode;
  logic [31:0]          mem_a_address;
  logic [3:0]           mem_a_mask;
  logic [31:0]          mem_a_data;
  logic [SRC_W-1:0]     mem_a_source;
  logic                 mem_d_valid;
  logic                 mem_d_ready;
  logic [2:0]           mem_d_opcode;
  logic [31:0]          mem_d_data;
  logic [NREQ-1:0]      rsp_d_valid;
  logic [NREQ-1:0]      rsp_d_ready;
  logic [2:0]           rsp_d_opcode;
  logic [31:0]          rsp_d_data;
  logic [$clog2(DEPTH):0] outstanding;
  logic                 err_orphan_d;
  logic [32*NREQ-1:0]   perf_grants;

  int tests;
  int fails;

  pinwheel_bus_arbiter #(
    .NREQ       (NREQ),
    .SRC_W      (SRC_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock         (clock),
    .reset_n_in    (reset_n_in),
    .req_a_valid   (req_a_valid),
    .req_a_ready   (req_a_ready),
    .req_a_opcode  (req_a_opcode),
    .req_a_address (req_a_address),
    .req_a_mask    (req_a_mask),
    .req_a_data    (req_a_data),
    .mem_a_valid   (mem_a_valid),
    .mem_a_ready   (mem_a_ready),
    .mem_a_opcode  (mem_a_opcode),
    .mem_a_address (mem_a_address),
    .mem_a_mask    (mem_a_mask),
    .mem_a_data    (mem_a_data),
    .mem_a_source  (mem_a_source),
    .mem_d_valid   (mem_d_valid),
    .mem_d_ready   (mem_d_ready),
    .mem_d_opcode  (mem_d_opcode),
    .mem_d_data    (mem_d_data),
    .rsp_d_valid   (rsp_d_valid),
    .rsp_d_ready   (rsp_d_ready),
    .rsp_d_opcode  (rsp_d_opcode),
    .rsp_d_data    (rsp_d_data),
    .outstanding   (outstanding),
    .err_orphan_d  (err_orphan_d),
    .perf_grants   (perf_grants)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    reset_n_in    = 1'b0;
    req_a_valid   = '0;
    req_a_opcode  = {OP_PUTP, OP_GET};
    req_a_address = {32'h0000_0200, 32'h8000_0010};
    req_a_mask    = {4'h3, 4'hF};
    req_a_data    = {32'hCAFE_0001, 32'h0000_0000};
    mem_a_ready   = 1'b0;
    mem_d_valid   = 1'b0;
    mem_d_opcode  = OP_ACK;
    mem_d_data    = '0;
    rsp_d_ready   = '0;

    // Reset state
    tick();
    tick();
    chk("rst_mem_a_valid", 64'(mem_a_valid), 64'd0);
    chk("rst_req_a_ready", 64'(req_a_ready), 64'd0);
    chk("rst_mem_d_ready", 64'(mem_d_ready), 64'd0);
    chk("rst_rsp_d_valid", 64'(rsp_d_valid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err",         64'(err_orphan_d), 64'd0);
    chk("rst_perf",        64'(perf_grants), 64'd0);
    reset_n_in = 1'b1;
    tick();

    // Test 1: single Get from requester 0, then AccessAckData back
    req_a_valid = 2'b01;
    settle();
    chk("t1_ready", 64'(req_a_ready), 64'b01);
    tick();
    req_a_valid = 2'b00;
    settle();
    chk("t1_mem_valid",  64'(mem_a_valid),   64'd1);
    chk("t1_mem_source", 64'(mem_a_source),  64'd0);
    chk("t1_mem_addr",   64'(mem_a_address), 64'h8000_0010);
    chk("t1_mem_opcode", 64'(mem_a_opcode),  64'(OP_GET));
    chk("t1_mem_mask",   64'(mem_a_mask),    64'hF);
    chk("t1_outst",      64'(outstanding),   64'd1);
    mem_a_ready = 1'b1;
    tick();
    chk("t1_slot_drop", 64'(mem_a_valid), 64'd0);
    mem_d_valid  = 1'b1;
    mem_d_opcode = OP_ACKD;
    mem_d_data   = 32'hDEAD_BEEF;
    rsp_d_ready  = 2'b01;
    settle();
    chk("t1_rsp_valid",  64'(rsp_d_valid),  64'b01);
    chk("t1_rsp_data",   64'(rsp_d_data),   64'hDEAD_BEEF);
    chk("t1_rsp_opcode", 64'(rsp_d_opcode), 64'(OP_ACKD));
    chk("t1_d_ready",    64'(mem_d_ready),  64'd1);
    tick();
    mem_d_valid = 1'b0;
    rsp_d_ready = 2'b00;
    settle();
    chk("t1_outst_pop", 64'(outstanding), 64'd0);

    // Test 2: both requesters valid, pointer last at 0 so requester 1 goes first
    req_a_valid = 2'b11;
    settle();
    chk("t2_ready_a", 64'(req_a_ready), 64'b10);
    tick();
    chk("t2_src_a",   64'(mem_a_source),  64'd1);
    chk("t2_addr_a",  64'(mem_a_address), 64'h0000_0200);
    chk("t2_data_a",  64'(mem_a_data),    64'hCAFE_0001);
    chk("t2_ready_b", 64'(req_a_ready),   64'b01);
    tick();
    chk("t2_src_b",   64'(mem_a_source),  64'd0);
    chk("t2_outst_b", 64'(outstanding),   64'd2);

    // Test 3: target stalls for three cycles with the slot full
    mem_a_ready = 1'b0;
    settle();
    chk("t3_ready_stall", 64'(req_a_ready), 64'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_valid", 64'(mem_a_valid),   64'd1);
      chk("t3_hold_addr",  64'(mem_a_address), 64'h8000_0010);
      chk("t3_hold_src",   64'(mem_a_source),  64'd0);
      chk("t3_hold_ready", 64'(req_a_ready),   64'b00);
    end
    chk("t3_outst", 64'(outstanding), 64'd2);
    mem_a_ready = 1'b1;
    settle();
    chk("t3_resume_ready", 64'(req_a_ready), 64'b10);
    tick();
    chk("t3_src_c",   64'(mem_a_source), 64'd1);
    chk("t3_ready_d", 64'(req_a_ready),  64'b01);
    tick();

    // Test 4: FIFO full blocks grants; a popping D beat lets one through
    chk("t4_outst_full", 64'(outstanding),  64'd4);
    chk("t4_ready_full", 64'(req_a_ready),  64'b00);
    chk("t4_src_d",      64'(mem_a_source), 64'd0);
    mem_d_valid  = 1'b1;
    mem_d_opcode = OP_ACK;
    mem_d_data   = 32'h0000_0000;
    rsp_d_ready  = 2'b10;
    settle();
    chk("t4_rsp_valid",  64'(rsp_d_valid), 64'b10);
    chk("t4_d_ready",    64'(mem_d_ready), 64'd1);
    chk("t4_ready_pop",  64'(req_a_ready), 64'b10);
    tick();
    chk("t4_outst_same", 64'(outstanding),  64'd4);
    chk("t4_src_e",      64'(mem_a_source), 64'd1);

    // Test 5: head ordering -- head is 0, then 1, and a wrong ready holds the beat
    req_a_valid = 2'b00;
    rsp_d_ready = 2'b01;
    settle();
    chk("t5_rsp_head0", 64'(rsp_d_valid), 64'b01);
    tick();
    chk("t5_outst_3", 64'(outstanding), 64'd3);
    settle();
    chk("t5_d_ready_hold", 64'(mem_d_ready), 64'd0);
    chk("t5_rsp_head1",    64'(rsp_d_valid), 64'b10);
    tick();
    chk("t5_outst_held", 64'(outstanding), 64'd3);
    rsp_d_ready = 2'b10;
    settle();
    chk("t5_d_ready_go", 64'(mem_d_ready), 64'd1);
    tick();
    chk("t5_outst_2", 64'(outstanding), 64'd2);
    rsp_d_ready = 2'b11;
    tick();
    tick();
    mem_d_valid = 1'b0;
    settle();
    chk("t5_outst_0", 64'(outstanding),  64'd0);
    chk("t5_err_0",   64'(err_orphan_d), 64'd0);
    chk("t5_slot_0",  64'(mem_a_valid),  64'd0);
`ifdef PINWHEEL_ARB_PERF_EN
    chk("t5_perf0", 64'(perf_grants[31:0]),  64'd3);
    chk("t5_perf1", 64'(perf_grants[63:32]), 64'd3);
`else
    chk("t5_perf_off", 64'(perf_grants), 64'd0);
`endif

    // Test 6: orphan D beat is drained and sets the sticky error
    rsp_d_ready = 2'b00;
    mem_d_valid = 1'b1;
    settle();
    chk("t6_d_ready", 64'(mem_d_ready),  64'd1);
    chk("t6_rsp_0",   64'(rsp_d_valid),  64'b00);
    chk("t6_err_pre", 64'(err_orphan_d), 64'd0);
    tick();
    mem_d_valid = 1'b0;
    tick();
    chk("t6_err_sticky", 64'(err_orphan_d), 64'd1);
    chk("t6_outst",      64'(outstanding),  64'd0);
    reset_n_in = 1'b0;
    settle();
    chk("t6_err_rst",  64'(err_orphan_d), 64'd0);
    chk("t6_perf_rst", 64'(perf_grants),  64'd0);
    tick();
    reset_n_in = 1'b1;
    tick();

    // Reset pointer favours requester 0; reset mid-transaction discards state
    req_a_valid = 2'b11;
    settle();
    chk("t7_rr_reset", 64'(req_a_ready), 64'b01);
    tick();
    req_a_valid = 2'b00;
    chk("t7_outst_1", 64'(outstanding), 64'd1);
    reset_n_in = 1'b0;
    settle();
    chk("t7_outst_rst", 64'(outstanding), 64'd0);
    chk("t7_slot_rst",  64'(mem_a_valid), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
